// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: ALU op classes, datapath
// select codes, opcodes, FSM states and the one-hot instruction class.
package multicycle_ctrl_pkg;

  localparam int ALU_OP_WIDTH = 3;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD         = 3'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ARITH_LOGIC = 3'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_BRANCH      = 3'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LUI         = 3'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AUIPC       = 3'd4;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_RS1    = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RESULT_ALUOUT = 2'd0;
  localparam logic [1:0] RESULT_MEM    = 2'd1;
  localparam logic [1:0] RESULT_ALU    = 2'd2;
  localparam logic [1:0] RESULT_MULDIV = 2'd3;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_MULDIV   = 4'd14,
    S_HALT     = 4'd15
  } state_t;

  // Exactly one bit is set for any opcode; illegal catches everything unlisted.
  typedef struct packed {
    logic load;
    logic store;
    logic alu_r;
    logic muldiv;
    logic alu_i;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_instr_class.sv
// Combinational opcode/funct7 classifier feeding the DECODE dispatch.
module instr_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]   i_op,
  input  logic [6:0]   i_funct7,
  output instr_class_t o_class
);

  always_comb begin
    o_class = '0;
    case (i_op)
      OPC_LOAD:   o_class.load   = 1'b1;
      OPC_STORE:  o_class.store  = 1'b1;
      OPC_OP: begin
        if (i_funct7 == FUNCT7_MULDIV) o_class.muldiv = 1'b1;
        else                           o_class.alu_r  = 1'b1;
      end
      OPC_OP_IMM: o_class.alu_i  = 1'b1;
      OPC_BRANCH: o_class.branch = 1'b1;
      OPC_JAL:    o_class.jal    = 1'b1;
      OPC_JALR:   o_class.jalr   = 1'b1;
      OPC_LUI:    o_class.lui    = 1'b1;
      OPC_AUIPC:  o_class.auipc  = 1'b1;
      default:    o_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the rv32im multicycle core. Define KIANV_RV32M_EN to
// build the MULDIV state; otherwise mul/div instructions halt as illegal.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              op,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic                    take_branch,
  input  logic                    mem_ready,
  input  logic                    muldiv_ready,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic                    adr_src,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    old_pc_write,
  output logic                    reg_write,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              result_src,
  output logic [ALU_OP_WIDTH-1:0] ALUOp,
  output logic                    muldiv_valid,
  output logic                    illegal_instr
);

  state_t       r_state;
  state_t       w_next_state;
  logic         r_jump;
  logic         w_next_jump;
  instr_class_t w_class;
  logic         w_unused;

  instr_class u_instr_class (
    .i_op     (op),
    .i_funct7 (funct7),
    .o_class  (w_class)
  );

  // funct3 is consumed by the ALU decoder, not by the sequencer.
`ifdef KIANV_RV32M_EN
  assign w_unused = ^{funct3, w_class.illegal};
`else
  assign w_unused = ^{funct3, w_class.illegal, muldiv_ready};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_jump  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_jump  <= w_next_jump;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_jump  = 1'b0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_class.load || w_class.store) w_next_state = S_MEMADR;
        else if (w_class.alu_r)            w_next_state = S_EXECR;
`ifdef KIANV_RV32M_EN
        else if (w_class.muldiv)           w_next_state = S_MULDIV;
`else
        else if (w_class.muldiv)           w_next_state = S_HALT;
`endif
        else if (w_class.alu_i)            w_next_state = S_EXECI;
        else if (w_class.branch)           w_next_state = S_BRANCH;
        else if (w_class.jal)              w_next_state = S_JAL;
        else if (w_class.jalr)             w_next_state = S_JALR;
        else if (w_class.lui)              w_next_state = S_LUI;
        else if (w_class.auipc)            w_next_state = S_AUIPC;
        else                               w_next_state = S_HALT;
      end
      S_MEMADR:   w_next_state = w_class.store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
      S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH: w_next_state = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: w_next_state = S_ALUWB;
      // The jump flag makes ALUWB write the return address old_pc+4.
      S_JAL, S_JALR: begin
        w_next_state = S_ALUWB;
        w_next_jump  = 1'b1;
      end
`ifdef KIANV_RV32M_EN
      S_MULDIV:   if (muldiv_ready) w_next_state = S_FETCH;
`endif
      S_HALT:     w_next_state = S_HALT;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    mem_valid     = 1'b0;
    mem_we        = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    old_pc_write  = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RESULT_ALUOUT;
    ALUOp         = ALU_OP_ADD;
    muldiv_valid  = 1'b0;
    illegal_instr = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_valid    = 1'b1;
          alu_src_b    = SRC_B_FOUR;
          result_src   = RESULT_ALU;
          ir_write     = mem_ready;
          old_pc_write = mem_ready;
          pc_write     = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_MEMREAD: begin
          mem_valid = 1'b1;
          adr_src   = 1'b1;
        end
        S_MEMWRITE: begin
          mem_valid = 1'b1;
          adr_src   = 1'b1;
          mem_we    = 1'b1;
        end
        S_MEMWB: begin
          result_src = RESULT_MEM;
          reg_write  = 1'b1;
        end
        S_EXECR: begin
          ALUOp     = ALU_OP_ARITH_LOGIC;
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_RS2;
        end
        S_EXECI: begin
          ALUOp     = ALU_OP_ARITH_LOGIC;
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_LUI: begin
          ALUOp     = ALU_OP_LUI;
          alu_src_b = SRC_B_IMM;
        end
        S_AUIPC: begin
          ALUOp     = ALU_OP_AUIPC;
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          if (r_jump) begin
            alu_src_a  = SRC_A_OLD_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RESULT_ALU;
          end else begin
            result_src = RESULT_ALUOUT;
          end
        end
        S_BRANCH: begin
          ALUOp      = ALU_OP_BRANCH;
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          result_src = RESULT_ALUOUT;
          pc_write   = take_branch;
        end
        S_JAL: begin
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RESULT_ALUOUT;
          pc_write   = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          result_src = RESULT_ALU;
          pc_write   = 1'b1;
        end
`ifdef KIANV_RV32M_EN
        S_MULDIV: begin
          muldiv_valid = 1'b1;
          result_src   = RESULT_MULDIV;
          reg_write    = muldiv_ready;
        end
`endif
        S_HALT:  illegal_instr = 1'b1;
        default: illegal_instr = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle scripts built
// from the control rules; honours KIANV_RV32M_EN like the design does.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic take_branch = 1'b0;
  logic mem_ready = 1'b0;
  logic muldiv_ready = 1'b0;
  logic mem_valid, mem_we, adr_src, ir_write, pc_write, old_pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [ALU_OP_WIDTH-1:0] ALUOp;
  logic muldiv_valid, illegal_instr;

  typedef struct packed {
    logic       mem_valid, mem_we, adr_src, ir_write, pc_write, old_pc_write, reg_write;
    logic [1:0] src_a, src_b, result_src;
    logic [2:0] alu_op;
    logic       muldiv_valid, illegal;
  } ctrl_t;

  typedef struct packed {
    logic       rst, mem_ready, muldiv_ready, take_branch;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
  } stim_t;

  typedef enum int {K_LOAD, K_STORE, K_R, K_MUL, K_I, K_BR, K_JAL, K_JALR,
                    K_LUI, K_AUIPC, K_ILL} kind_t;

  stim_t stimQ[$];
  ctrl_t expQ[$];
  string tagQ[$];
  logic [6:0] curOp = '0;
  logic [6:0] curF7 = '0;
  int vectors = 0;
  int miscompares = 0;
  ctrl_t actual;

  assign actual = {mem_valid, mem_we, adr_src, ir_write, pc_write, old_pc_write,
                   reg_write, alu_src_a, alu_src_b, result_src, ALUOp,
                   muldiv_valid, illegal_instr};

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .take_branch(take_branch), .mem_ready(mem_ready), .muldiv_ready(muldiv_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .old_pc_write(old_pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .ALUOp(ALUOp), .muldiv_valid(muldiv_valid),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Random handshake noise; ignored by the controller outside waiting states.
  task automatic noise(output stim_t s);
    s.rst          = 1'b0;
    s.mem_ready    = 1'($urandom_range(0, 1));
    s.muldiv_ready = 1'($urandom_range(0, 1));
    s.take_branch  = 1'($urandom_range(0, 1));
    s.op           = curOp;
    s.funct7       = curF7;
    s.funct3       = 3'($urandom_range(0, 7));
  endtask

  task automatic push(input stim_t s, input ctrl_t e, input string tag);
    stimQ.push_back(s);
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic addReset(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      noise(s);
      s.rst = 1'b1;
      push(s, '0, "reset");
    end
  endtask

  task automatic addSimple(input ctrl_t e, input string tag);
    stim_t s;
    noise(s);
    push(s, e, tag);
  endtask

  // One instruction: fetch (with wait states), decode, then its own phases.
  task automatic applyStimulus(input kind_t k, input int fWait, input int mWait,
                               input bit take, input bit abort);
    stim_t s;
    ctrl_t e;
    logic [6:0] illOps [4];
    illOps = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};
    curF7 = 7'($urandom_range(0, 127));
    case (k)
      K_LOAD:  curOp = OPC_LOAD;
      K_STORE: curOp = OPC_STORE;
      K_R:     begin curOp = OPC_OP; curF7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000; end
      K_MUL:   begin curOp = OPC_OP; curF7 = 7'b0000001; end
      K_I:     curOp = OPC_OP_IMM;
      K_BR:    curOp = OPC_BRANCH;
      K_JAL:   curOp = OPC_JAL;
      K_JALR:  curOp = OPC_JALR;
      K_LUI:   curOp = OPC_LUI;
      K_AUIPC: curOp = OPC_AUIPC;
      default: curOp = illOps[$urandom_range(0, 3)];
    endcase

    for (int i = 0; i <= fWait; i++) begin
      noise(s);
      s.mem_ready = (i == fWait);
      e = '0;
      e.mem_valid = 1'b1; e.src_b = 2'd2; e.result_src = 2'd2;
      e.ir_write = s.mem_ready; e.pc_write = s.mem_ready; e.old_pc_write = s.mem_ready;
      push(s, e, "fetch");
    end
    e = '0; e.src_a = 2'd1; e.src_b = 2'd1;
    addSimple(e, "decode");

    case (k)
      K_LOAD, K_STORE: begin
        e = '0; e.src_a = 2'd2; e.src_b = 2'd1;
        addSimple(e, "memadr");
        for (int i = 0; i <= mWait; i++) begin
          noise(s);
          s.mem_ready = (i == mWait);
          if (abort && s.mem_ready) begin
            addReset(1 + $urandom_range(0, 1));
            return;
          end
          e = '0; e.mem_valid = 1'b1; e.adr_src = 1'b1; e.mem_we = (k == K_STORE);
          push(s, e, (k == K_STORE) ? "memwrite" : "memread");
        end
        if (k == K_LOAD) begin
          e = '0; e.result_src = 2'd1; e.reg_write = 1'b1;
          addSimple(e, "memwb");
        end
      end
      K_R, K_I, K_LUI, K_AUIPC: begin
        e = '0;
        if (k == K_R)     begin e.alu_op = ALU_OP_ARITH_LOGIC; e.src_a = 2'd2; e.src_b = 2'd0; end
        if (k == K_I)     begin e.alu_op = ALU_OP_ARITH_LOGIC; e.src_a = 2'd2; e.src_b = 2'd1; end
        if (k == K_LUI)   begin e.alu_op = ALU_OP_LUI; e.src_b = 2'd1; end
        if (k == K_AUIPC) begin e.alu_op = ALU_OP_AUIPC; e.src_a = 2'd1; e.src_b = 2'd1; end
        addSimple(e, "exec");
        e = '0; e.reg_write = 1'b1; e.result_src = 2'd0;
        addSimple(e, "aluwb");
      end
      K_BR: begin
        noise(s);
        s.take_branch = take;
        e = '0; e.alu_op = ALU_OP_BRANCH; e.src_a = 2'd2; e.src_b = 2'd0;
        e.pc_write = take;
        push(s, e, "branch");
      end
      K_JAL, K_JALR: begin
        e = '0; e.pc_write = 1'b1;
        if (k == K_JAL) begin e.src_a = 2'd1; e.src_b = 2'd2; e.result_src = 2'd0; end
        else            begin e.src_a = 2'd2; e.src_b = 2'd1; e.result_src = 2'd2; end
        addSimple(e, "jump");
        e = '0; e.reg_write = 1'b1; e.src_a = 2'd1; e.src_b = 2'd2; e.result_src = 2'd2;
        addSimple(e, "linkwb");
      end
`ifdef KIANV_RV32M_EN
      K_MUL: begin
        for (int i = 0; i <= mWait; i++) begin
          noise(s);
          s.muldiv_ready = (i == mWait);
          e = '0; e.muldiv_valid = 1'b1; e.result_src = 2'd3; e.reg_write = s.muldiv_ready;
          push(s, e, "muldiv");
        end
      end
`endif
      default: begin
        e = '0; e.illegal = 1'b1;
        for (int i = 0; i < 1 + $urandom_range(0, 2); i++) addSimple(e, "halt");
        addReset(1 + $urandom_range(0, 1));
      end
    endcase
  endtask

  initial begin
    addReset(2);
    applyStimulus(K_R, 0, 0, 1'b0, 1'b0);
    applyStimulus(K_LOAD, 0, 3, 1'b0, 1'b0);
    applyStimulus(K_BR, 0, 0, 1'b1, 1'b0);
    applyStimulus(K_BR, 0, 0, 1'b0, 1'b0);
    applyStimulus(K_JAL, 0, 0, 1'b0, 1'b0);
    applyStimulus(K_MUL, 0, 4, 1'b0, 1'b0);
    applyStimulus(K_LOAD, 0, 3, 1'b0, 1'b1);
    applyStimulus(K_ILL, 1, 0, 1'b0, 1'b0);
    for (int n = 0; n < 250; n++) begin
      kind_t k;
      k = kind_t'($urandom_range(0, 10));
      applyStimulus(k, $urandom_range(0, 2), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)),
                    (k == K_LOAD) && ($urandom_range(0, 5) == 0));
    end

    for (int i = 0; i < stimQ.size(); i++) begin
      @(posedge clk);
      #1;
      rst          = stimQ[i].rst;
      mem_ready    = stimQ[i].mem_ready;
      muldiv_ready = stimQ[i].muldiv_ready;
      take_branch  = stimQ[i].take_branch;
      op           = stimQ[i].op;
      funct7       = stimQ[i].funct7;
      funct3       = stimQ[i].funct3;
      @(negedge clk);
      checkOutput($sformatf("c%0d_%s", i, tagQ[i]), {14'd0, actual}, {14'd0, expQ[i]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
